// File: rtl/exe_div_pkg.sv
// Shared types and constants for the EXE-stage sequential divider and its alu.
package exe_div_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/exe_div_alu.sv
// 32-bit combinational alu: add with carry-in, and, or, xor; no carry-out port.
// Zero latency, no flow control.
module alu
  import exe_div_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cin,
  input  logic [1:0]  cmd,
  output logic [31:0] res
);

  always_comb begin
    res = '0;
    case (cmd)
      ALU_ADD: res = op1 + op2 + {31'b0, cin};
      ALU_AND: res = op1 & op2;
      ALU_OR:  res = op1 | op2;
      ALU_XOR: res = op1 ^ op2;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/exe_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 36 cycles accept->done (2 with DIV_FAST_SPECIAL_EN for /0 and overflow);
// starts ignored while busy, result held with done until ack, flush aborts.
module exe_div_seq
  import exe_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_SE,
  input  logic [1:0]      op_SE,
  input  logic [XLEN-1:0] dividend_SE,
  input  logic [XLEN-1:0] divisor_SE,
  input  logic            flush_SE,
  input  logic            res_ack_SE,
  output logic            busy_SE,
  output logic            done_SE,
  output logic [XLEN-1:0] res_SE
);

  div_state_e      state_q;
  div_op_e         op_q;
  logic [XLEN-1:0] a_q, d_q, r_q;
  logic [4:0]      cnt_q;
  logic            sa_q, qneg_q, rneg_q;

  logic [XLEN-1:0] alu_op1, alu_op2, alu_res;
  logic            alu_cin;
  logic [1:0]      alu_cmd;

  logic [XLEN-1:0] r_shift, fix_val;
  logic            fix_neg, cout, neg_a, neg_b;

  alu u_alu (
    .op1 (alu_op1),
    .op2 (alu_op2),
    .cin (alu_cin),
    .cmd (alu_cmd),
    .res (alu_res)
  );

  always_comb begin
    r_shift = {r_q[XLEN-2:0], a_q[XLEN-1]};
    fix_val = op_is_rem(op_q) ? r_q : a_q;
    fix_neg = op_is_rem(op_q) ? rneg_q : qneg_q;
    neg_a   = op_is_signed(op_q) & a_q[XLEN-1];
    neg_b   = op_is_signed(op_q) & d_q[XLEN-1];
    alu_op1 = '0;
    alu_op2 = '0;
    alu_cin = 1'b0;
    alu_cmd = ALU_ADD;
    case (state_q)
      S_NEG_A: if (neg_a) begin alu_op2 = ~a_q; alu_cin = 1'b1; end
      S_NEG_B: if (neg_b) begin alu_op2 = ~d_q; alu_cin = 1'b1; end
      S_ITER: begin
        alu_op1 = r_shift;
        alu_op2 = ~d_q;
        alu_cin = 1'b1;
      end
      S_FIX: begin
        if (fix_neg) begin
          alu_op2 = ~fix_val;
          alu_cin = 1'b1;
        end else begin
          alu_op1 = fix_val;
        end
      end
      default: ;
    endcase
    // carry-out of R' + ~D + 1 rebuilt from the sign bits; R' never needs a 33rd bit
    cout = (r_shift[XLEN-1] & ~d_q[XLEN-1]) |
           ((r_shift[XLEN-1] ^ ~d_q[XLEN-1]) & ~alu_res[XLEN-1]);
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (d_q == '0) begin
      fast_hit = 1'b1;
      fast_res = op_is_rem(op_q) ? a_q : '1;
    end else if (op_is_signed(op_q) && a_q == {1'b1, {(XLEN-1){1'b0}}} && d_q == '1) begin
      fast_hit = 1'b1;
      fast_res = op_is_rem(op_q) ? '0 : a_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= DIV;
      a_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_SE <= 1'b0;
      done_SE <= 1'b0;
      res_SE  <= '0;
    end else if (flush_SE) begin
      state_q <= S_IDLE;
      busy_SE <= 1'b0;
      done_SE <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_SE) begin
            a_q     <= dividend_SE;
            d_q     <= divisor_SE;
            op_q    <= div_op_e'(op_SE);
            r_q     <= '0;
            busy_SE <= 1'b1;
            state_q <= S_NEG_A;
          end
        end
        S_NEG_A: begin
`ifdef DIV_FAST_SPECIAL_EN
          if (fast_hit) begin
            res_SE  <= fast_res;
            state_q <= S_DONE;
          end else
`endif
          begin
            sa_q <= neg_a;
            if (neg_a) a_q <= alu_res;
            state_q <= S_NEG_B;
          end
        end
        S_NEG_B: begin
          // x/0 must give all-ones even for a negative dividend, so no quotient negate
          qneg_q  <= op_is_signed(op_q) & (sa_q ^ d_q[XLEN-1]) & (|d_q);
          rneg_q  <= sa_q;
          if (neg_b) d_q <= alu_res;
          cnt_q   <= 5'(DIV_ITERS - 1);
          state_q <= S_ITER;
        end
        S_ITER: begin
          r_q   <= cout ? alu_res : r_shift;
          a_q   <= {a_q[XLEN-2:0], cout};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= S_FIX;
        end
        S_FIX: begin
          res_SE  <= alu_res;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (done_SE && res_ack_SE) begin
            done_SE <= 1'b0;
            busy_SE <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_SE <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_seq.sv
// Directed and randomized bench for exe_div_seq against a behavioural divide model.
module tb_exe_div_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_SE = 1'b0;
  logic [1:0]  op_SE = 2'b00;
  logic [31:0] dividend_SE = '0;
  logic [31:0] divisor_SE = '0;
  logic        flush_SE = 1'b0;
  logic        res_ack_SE = 1'b0;
  logic        busy_SE, done_SE;
  logic [31:0] res_SE;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp = '0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 36;
`endif

  always #5 clk = ~clk;

  exe_div_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_SE    (start_SE),
    .op_SE       (op_SE),
    .dividend_SE (dividend_SE),
    .divisor_SE  (divisor_SE),
    .flush_SE    (flush_SE),
    .res_ack_SE  (res_ack_SE),
    .busy_SE     (busy_SE),
    .done_SE     (done_SE),
    .res_SE      (res_SE)
  );

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Issues one op, returns the result and the number of edges from accept to done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ack_dly, output logic [31:0] res, output int lat);
    @(negedge clk);
    start_SE = 1'b1; op_SE = op; dividend_SE = a; divisor_SE = b;
    @(posedge clk); #1;
    start_SE = 1'b0;
    lat = 0;
    while (!done_SE && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = res_SE;
    repeat (ack_dly) @(posedge clk);
    @(negedge clk); res_ack_SE = 1'b1;
    @(posedge clk); #1; res_ack_SE = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy_SE !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_SE); end
    checks++; if (done_SE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_SE); end
    checks++; if (res_SE !== 32'd0) begin errors++; $display("FAIL reset_res got %h expected 0", res_SE); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat;
    run_op(2'b01, 32'd100, 32'd7, 0, r, lat);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h expected %h", r, 32'd14); end
    checks++; if (lat !== 36) begin errors++; $display("FAIL divu_latency got %0d expected 36", lat); end
    checks++; if (busy_SE !== 1'b0) begin errors++; $display("FAIL busy_after_ack got %b expected 0", busy_SE); end
    run_op(2'b11, 32'd100, 32'd7, 2, r, lat);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h expected %h", r, 32'd2); end
  endtask

  task automatic test_signed_special();
    logic [1:0]  ops [8] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11};
    logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                            32'd1234, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5};
    logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] exs [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5};
    int          lts [8] = '{36, 36, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT};
    logic [31:0] r; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 0, r, lat);
      checks++; if (r !== exs[i]) begin errors++; $display("FAIL vec%0d_res got %h expected %h", i, r, exs[i]); end
      checks++; if (lat !== lts[i]) begin errors++; $display("FAIL vec%0d_latency got %0d expected %0d", i, lat, lts[i]); end
      last_exp = exs[i];
    end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat;
    @(negedge clk);
    start_SE = 1'b1; op_SE = 2'b01; dividend_SE = 32'd1000; divisor_SE = 32'd3;
    @(posedge clk); #1; start_SE = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); flush_SE = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_SE !== 1'b0) begin errors++; $display("FAIL flush_busy got %b expected 0", busy_SE); end
    checks++; if (done_SE !== 1'b0) begin errors++; $display("FAIL flush_done got %b expected 0", done_SE); end
    checks++; if (res_SE !== last_exp) begin errors++; $display("FAIL flush_res_kept got %h expected %h", res_SE, last_exp); end
    @(negedge clk); start_SE = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_SE !== 1'b0) begin errors++; $display("FAIL flush_beats_start got %b expected 0", busy_SE); end
    start_SE = 1'b0; flush_SE = 1'b0;
    run_op(2'b01, 32'd9, 32'd3, 0, r, lat);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL after_flush_res got %h expected 3", r); end
    checks++; if (lat !== 36) begin errors++; $display("FAIL after_flush_latency got %0d expected 36", lat); end
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk);
    start_SE = 1'b1; op_SE = 2'b01; dividend_SE = 32'd50; divisor_SE = 32'd5;
    @(posedge clk); #1; start_SE = 1'b0;
    lat = 0;
    while (!done_SE && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 36) begin errors++; $display("FAIL hold_latency got %0d expected 36", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start_SE = 1'b1; dividend_SE = 32'd99; divisor_SE = 32'd1;
      @(posedge clk); #1;
      checks++; if (done_SE !== 1'b1) begin errors++; $display("FAIL hold_done%0d got %b expected 1", i, done_SE); end
      checks++; if (res_SE !== 32'd10) begin errors++; $display("FAIL hold_res%0d got %h expected %h", i, res_SE, 32'd10); end
    end
    @(negedge clk); res_ack_SE = 1'b1;
    @(posedge clk); #1;
    res_ack_SE = 1'b0;
    checks++; if (busy_SE !== 1'b0) begin errors++; $display("FAIL ack_start_ignored got %b expected 0", busy_SE); end
    checks++; if (done_SE !== 1'b0) begin errors++; $display("FAIL ack_clears_done got %b expected 0", done_SE); end
    start_SE = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] r; int lat;
    @(negedge clk);
    start_SE = 1'b1; op_SE = 2'b01; dividend_SE = 32'hFFFF_FFFF; divisor_SE = 32'd3;
    @(posedge clk); #1; start_SE = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy_SE !== 1'b0) begin errors++; $display("FAIL arst_busy got %b expected 0", busy_SE); end
    checks++; if (res_SE !== 32'd0) begin errors++; $display("FAIL arst_res got %h expected 0", res_SE); end
    @(negedge clk); reset_n = 1'b1;
    run_op(2'b00, 32'hFFFF_FFEC, 32'd4, 1, r, lat);
    checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL after_arst_res got %h expected %h", r, 32'hFFFF_FFFB); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e; logic [1:0] op; int lat, elat;
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      e = ref_model(op, a, b);
      elat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? SPECIAL_LAT : 36;
      run_op(op, a, b, int'($urandom_range(0, 3)), r, lat);
      checks++; if (r !== e) begin errors++; $display("FAIL rand%0d op%0d %h/%h got %h expected %h", n, op, a, b, r, e); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency got %0d expected %0d", n, lat, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_special();
    test_flush();
    test_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
